// File: rtl/ncpu32k_dbus_sram_pkg.sv
// rtl/ncpu32k_dbus_sram_pkg.sv - shared bus widths and dbus responder state encoding
package ncpu32k_dbus_sram_pkg;

  localparam int NCPU_AW = 32;
  localparam int NCPU_DW = 32;

  typedef enum logic [1:0] {
    NCPU_DBUS_ST_IDLE = 2'd0,
    NCPU_DBUS_ST_WAIT = 2'd1,
    NCPU_DBUS_ST_RESP = 2'd2
  } dbus_st_t;

endpackage

// File: rtl/ncpu32k_cell_sram_1p.sv
// rtl/ncpu32k_cell_sram_1p.sv - single-port synchronous SRAM, per-byte write enable, registered read
module ncpu32k_cell_sram_1p #(
  parameter int AW = 12,
  parameter int DW = 32
) (
  input  logic            clk,
  input  logic            en,
  input  logic [AW-1:0]   addr,
  input  logic [DW/8-1:0] we,
  input  logic [DW-1:0]   din,
  output logic [DW-1:0]   dout
);

  logic [DW-1:0] mem [0:(1<<AW)-1];

  // Read-first: dout captures the pre-write word; writers ignore it.
  always_ff @(posedge clk) begin
    if (en) begin
      for (int i = 0; i < DW/8; i++) begin
        if (we[i]) mem[addr][8*i +: 8] <= din[8*i +: 8];
      end
      dout <= mem[addr];
    end
  end

endmodule

// File: rtl/ncpu32k_dbus_sram.sv
// rtl/ncpu32k_dbus_sram.sv - dbus command/response target in front of local data SRAM
module ncpu32k_dbus_sram
  import ncpu32k_dbus_sram_pkg::*;
#(
  parameter int MEM_AW      = 12,
  parameter int WAIT_STATES = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 dbus_cmd_valid,
  output logic                 dbus_cmd_ready,
  input  logic [NCPU_AW-1:0]   dbus_cmd_addr,
  input  logic [NCPU_DW/8-1:0] dbus_cmd_we_msk,
  input  logic [NCPU_DW-1:0]   dbus_din,
  output logic                 dbus_valid,
  input  logic                 dbus_ready,
  output logic [NCPU_DW-1:0]   dbus_dout
);

  localparam logic [3:0] WS_LOAD = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);
  localparam bit NO_WAIT = (WAIT_STATES == 0);

  dbus_st_t             state;
  logic [3:0]           cnt;
  logic                 resp_zero;
  logic [MEM_AW-1:0]    cmd_idx;
  logic [NCPU_DW/8-1:0] cmd_msk;
  logic [NCPU_DW-1:0]   cmd_din;
  logic                 cmd_hs;
  logic                 acc_en;
  logic [MEM_AW-1:0]    acc_idx;
  logic [NCPU_DW/8-1:0] acc_msk;
  logic [NCPU_DW-1:0]   acc_din;
  logic [NCPU_DW-1:0]   sram_q;
  logic                 unused_addr;

  assign unused_addr = ^{dbus_cmd_addr[NCPU_AW-1:MEM_AW+2], dbus_cmd_addr[1:0]};

  assign dbus_cmd_ready = (state == NCPU_DBUS_ST_IDLE) |
                          ((state == NCPU_DBUS_ST_RESP) & dbus_ready);
  assign cmd_hs     = dbus_cmd_valid & dbus_cmd_ready;
  assign dbus_valid = (state == NCPU_DBUS_ST_RESP);

  // Zero-wait accesses use the live command; otherwise the latched copy.
  // Gating with rst_n drops any access coinciding with a reset edge.
  assign acc_en  = rst_n & (NO_WAIT ? cmd_hs
                                    : ((state == NCPU_DBUS_ST_WAIT) && (cnt == 4'd0)));
  assign acc_idx = NO_WAIT ? dbus_cmd_addr[MEM_AW+1:2] : cmd_idx;
  assign acc_msk = NO_WAIT ? dbus_cmd_we_msk : cmd_msk;
  assign acc_din = NO_WAIT ? dbus_din : cmd_din;

  // The SRAM output register doubles as the read response; stores mask it to 0.
  assign dbus_dout = resp_zero ? '0 : sram_q;

  always_ff @(posedge clk) begin
    if (cmd_hs) begin
      cmd_idx <= dbus_cmd_addr[MEM_AW+1:2];
      cmd_msk <= dbus_cmd_we_msk;
      cmd_din <= dbus_din;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= NCPU_DBUS_ST_IDLE;
      cnt       <= 4'd0;
      resp_zero <= 1'b1;
    end else begin
      if (acc_en) resp_zero <= |acc_msk;
      case (state)
        NCPU_DBUS_ST_IDLE, NCPU_DBUS_ST_RESP: begin
          if (cmd_hs) begin
            if (NO_WAIT) begin
              state <= NCPU_DBUS_ST_RESP;
            end else begin
              state <= NCPU_DBUS_ST_WAIT;
              cnt   <= WS_LOAD;
            end
          end else if (state == NCPU_DBUS_ST_RESP && dbus_ready) begin
            state <= NCPU_DBUS_ST_IDLE;
          end
        end
        NCPU_DBUS_ST_WAIT: begin
          if (cnt == 4'd0) state <= NCPU_DBUS_ST_RESP;
          else             cnt   <= cnt - 4'd1;
        end
        default: state <= NCPU_DBUS_ST_IDLE;
      endcase
    end
  end

  ncpu32k_cell_sram_1p #(
    .AW (MEM_AW),
    .DW (NCPU_DW)
  ) u_sram (
    .clk  (clk),
    .en   (acc_en),
    .addr (acc_idx),
    .we   (acc_msk),
    .din  (acc_din),
    .dout (sram_q)
  );

endmodule
